// File: rtl/spi_pkg.sv
// spi_pkg: definitions shared by the SPI master RTL and the bridge benches.
//   - spi_state_e : frame sequencer states
//   - SPI_DATA_W  : default bits per frame
//   - SPI_DIV     : default clk cycles per SCK half-period
package spi_pkg;

    localparam int SPI_DATA_W = 16;
    localparam int SPI_DIV    = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } spi_state_e;

endpackage

// File: rtl/spi_sck_gen.sv
// spi_sck_gen: SCK half-period timer for the SPI master.
// Counts 0..DIV-1 while enabled and wraps. Each wrap ends one half-period.
// Wraps alternate between rise and fall, starting with a rise after enable.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   en        : run the counter; when low, counter and phase clear
//   rise_stb  : one-cycle strobe, the next clk edge should drive sck high
//   fall_stb  : one-cycle strobe, the next clk edge should drive sck low
module spi_sck_gen
    import spi_pkg::*;
#(
    parameter int DIV = SPI_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             phase_q;
    logic             phase_d;
    logic             wrap_s;

    // Next counter/phase values and strobe decode from the registered counter.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        wrap_s  = en && (cnt_q == CNT_W'(DIV - 1));
        if (!en) begin
            cnt_d   = {CNT_W{1'b0}};
            phase_d = 1'b0;
        end else if (wrap_s) begin
            cnt_d   = {CNT_W{1'b0}};
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + CNT_W'(1);
        end
        // phase low means sck is currently low, so the wrap ends a low half.
        rise_stb = wrap_s && !phase_q;
        fall_stb = wrap_s && phase_q;
    end

    // Counter and phase registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= {CNT_W{1'b0}};
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/spi_master.sv
// spi_master: SPI mode-0 master, one chip-select framed transfer per word.
// MSB first in both directions; all outputs registered.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   tx_data, tx_valid  : word to send; accepted when tx_valid && tx_ready
//   tx_ready           : high only while idle
//   rx_data, rx_valid  : received word, updated with a one-cycle rx_valid pulse
//   busy               : high whenever a frame is in progress
//   sck, cs_n, mosi    : SPI outputs (sck idles low, cs_n active low)
//   miso               : SPI input, already synchronous to clk
module spi_master
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W,
    parameter int DIV    = SPI_DIV
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              sck,
    output logic              cs_n,
    output logic              mosi,
    input  logic              miso
);

    if (DATA_W < 2) begin : g_bad_data_w
        $error("spi_master: DATA_W must be at least 2");
    end
    if (DIV < 2) begin : g_bad_div
        $error("spi_master: DIV must be at least 2");
    end

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int GAP_W = (DIV > 1) ? $clog2(DIV) : 1;

    spi_state_e        state_q, state_d;
    logic [DATA_W-1:0] sr_q, sr_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              sck_q, sck_d;
    logic              cs_n_q, cs_n_d;
    logic              mosi_q, mosi_d;
    logic              tx_ready_q, tx_ready_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              gen_en_s;
    logic              rise_stb_s;
    logic              fall_stb_s;

    assign gen_en_s = (state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD);

    spi_sck_gen #(
        .DIV (DIV)
    ) u_sck_gen (
        .clk      (clk),
        .rst      (rst),
        .en       (gen_en_s),
        .rise_stb (rise_stb_s),
        .fall_stb (fall_stb_s)
    );

    // Frame sequencer: next state, shift register, counters and output values.
    // The MSB goes straight to mosi on accept and the rest is preloaded one
    // position up, so the LSB slot is free for the first miso sample.
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        bit_d      = bit_q;
        gap_d      = gap_q;
        sck_d      = sck_q;
        cs_n_d     = cs_n_q;
        mosi_d     = mosi_q;
        tx_ready_d = tx_ready_q;
        busy_d     = busy_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    state_d    = SETUP;
                    cs_n_d     = 1'b0;
                    tx_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    mosi_d     = tx_data[DATA_W-1];
                    sr_d       = {tx_data[DATA_W-2:0], 1'b0};
                    bit_d      = {BIT_W{1'b0}};
                end else begin
                    state_d    = IDLE;
                end
            end
            SETUP: begin
                if (rise_stb_s) begin
                    state_d = SHIFT;
                    sck_d   = 1'b1;
                    sr_d[0] = miso;
                end else begin
                    state_d = SETUP;
                end
            end
            SHIFT: begin
                if (rise_stb_s) begin
                    sck_d   = 1'b1;
                    sr_d[0] = miso;
                end else if (fall_stb_s) begin
                    sck_d = 1'b0;
                    // The final fall only ends the bit; mosi keeps the LSB.
                    if (bit_q == BIT_W'(DATA_W - 1)) begin
                        state_d = HOLD;
                    end else begin
                        mosi_d = sr_q[DATA_W-1];
                        sr_d   = {sr_q[DATA_W-2:0], 1'b0};
                        bit_d  = bit_q + BIT_W'(1);
                    end
                end else begin
                    state_d = SHIFT;
                end
            end
            HOLD: begin
                if (rise_stb_s || fall_stb_s) begin
                    state_d    = GAP;
                    cs_n_d     = 1'b1;
                    rx_data_d  = sr_q;
                    rx_valid_d = 1'b1;
                    gap_d      = {GAP_W{1'b0}};
                end else begin
                    state_d = HOLD;
                end
            end
            GAP: begin
                if (gap_q == GAP_W'(DIV - 1)) begin
                    state_d    = IDLE;
                    tx_ready_d = 1'b1;
                    busy_d     = 1'b0;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                sck_d      = 1'b0;
                cs_n_d     = 1'b1;
                tx_ready_d = 1'b1;
                busy_d     = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any frame on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sr_q       <= {DATA_W{1'b0}};
            bit_q      <= {BIT_W{1'b0}};
            gap_q      <= {GAP_W{1'b0}};
            sck_q      <= 1'b0;
            cs_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            rx_data_q  <= {DATA_W{1'b0}};
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            bit_q      <= bit_d;
            gap_q      <= gap_d;
            sck_q      <= sck_d;
            cs_n_q     <= cs_n_d;
            mosi_q     <= mosi_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign tx_ready = tx_ready_q;
    assign busy     = busy_q;
    assign sck      = sck_q;
    assign cs_n     = cs_n_q;
    assign mosi     = mosi_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule
